// File: rtl/calc_pkg.sv
// Shared types and helpers for the 3-bit signed calculator datapaths.
// Contents:
//   DVD_W_DEF / DVS_W_DEF : default divider magnitude widths
//   state_t               : divider sequencer states
//   sm_sign               : sign-magnitude sign cleanup (no -0)
package calc_pkg;

  localparam int unsigned DVD_W_DEF = 4;
  localparam int unsigned DVS_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // A zero magnitude always carries a positive sign.
  function automatic logic sm_sign(input logic sign, input logic nonzero);
    return sign & nonzero;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_in  : partial remainder before this step
//   dvd_bit : next dividend bit (MSB first)
//   dvs_mag : divisor magnitude
//   rem_out : partial remainder after this step
//   qbit    : quotient bit produced by this step
module div_step #(
  parameter int unsigned DVS_W = 2
) (
  input  logic [DVS_W:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [DVS_W-1:0] dvs_mag,
  output logic [DVS_W:0]   rem_out,
  output logic             qbit
);

  localparam int unsigned SH_W  = DVS_W + 2;
  localparam int unsigned REM_W = DVS_W + 1;

  logic [SH_W-1:0] shifted;
  logic [SH_W-1:0] dvs_ext;

  // Compare at full width so a zero divisor lets the remainder keep growing.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    dvs_ext = SH_W'(dvs_mag);
    qbit    = (shifted >= dvs_ext);
    rem_out = REM_W'(qbit ? (shifted - dvs_ext) : shifted);
  end

endmodule

// File: rtl/signed_div_seq.sv
// Iterative sign-magnitude restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted only when idle
//   dividend   : [DVD_W] sign, [DVD_W-1:0] magnitude
//   divisor    : [DVS_W] sign, [DVS_W-1:0] magnitude
//   busy       : sequencer not idle
//   done       : one-cycle pulse, results valid
//   quotient   : sign-magnitude quotient, held until replaced
//   remainder  : sign-magnitude remainder, held until replaced
//   dz         : divide-by-zero flag, valid with done
// Build option: DIV_ZERO_TRAP_EN short-circuits a zero divisor and raises dz.
module signed_div_seq
  import calc_pkg::*;
#(
  parameter int unsigned DVD_W = DVD_W_DEF,
  parameter int unsigned DVS_W = DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W:0]   dividend,
  input  logic [DVS_W:0]   divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W:0]   quotient,
  output logic [DVS_W:0]   remainder,
  output logic             dz
);

  localparam int unsigned CNT_W = $clog2(DVD_W + 1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [DVD_W-1:0]   dvd_sh, dvd_sh_d;   // dividend bits out, quotient bits in
  logic [DVS_W-1:0]   dvs_mag, dvs_mag_d;
  logic [DVS_W:0]     rem, rem_d;
  logic               q_sign, q_sign_d;
  logic               r_sign, r_sign_d;
  logic               busy_d, done_d, dz_d;
  logic [DVD_W:0]     quotient_d;
  logic [DVS_W:0]     remainder_d;
  logic [DVS_W:0]     step_rem;
  logic               step_qbit;
`ifdef DIV_ZERO_TRAP_EN
  logic               dz_pend, dz_pend_d;
`endif

  div_step #(.DVS_W(DVS_W)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd_sh[DVD_W-1]),
    .dvs_mag (dvs_mag),
    .rem_out (step_rem),
    .qbit    (step_qbit)
  );

  // Next-state, datapath and output computation.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    dvd_sh_d    = dvd_sh;
    dvs_mag_d   = dvs_mag;
    rem_d       = rem;
    q_sign_d    = q_sign;
    r_sign_d    = r_sign;
    done_d      = 1'b0;
    dz_d        = dz;
    quotient_d  = quotient;
    remainder_d = remainder;
`ifdef DIV_ZERO_TRAP_EN
    dz_pend_d   = dz_pend;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          dvd_sh_d  = dividend[DVD_W-1:0];
          dvs_mag_d = divisor[DVS_W-1:0];
          rem_d     = '0;
          cnt_d     = CNT_W'(DVD_W - 1);
          // -0 operands are treated as +0.
          q_sign_d  = sm_sign(dividend[DVD_W], |dividend[DVD_W-1:0])
                    ^ sm_sign(divisor[DVS_W], |divisor[DVS_W-1:0]);
          r_sign_d  = dividend[DVD_W];
          state_d   = CALC;
`ifdef DIV_ZERO_TRAP_EN
          dz_pend_d = 1'b0;
          if (divisor[DVS_W-1:0] == '0) begin
            dvd_sh_d  = '1;
            dz_pend_d = 1'b1;
            state_d   = DONE;
          end
`endif
        end
      end

      CALC: begin
        dvd_sh_d = {dvd_sh[DVD_W-2:0], step_qbit};
        rem_d    = step_rem;
        cnt_d    = cnt - CNT_W'(1);
        if (cnt == '0) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done_d      = 1'b1;
        quotient_d  = {sm_sign(q_sign, |dvd_sh), dvd_sh};
        remainder_d = {sm_sign(r_sign, |rem[DVS_W-1:0]), rem[DVS_W-1:0]};
`ifdef DIV_ZERO_TRAP_EN
        dz_d        = dz_pend;
`else
        dz_d        = 1'b0;
`endif
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd_sh    <= '0;
      dvs_mag   <= '0;
      rem       <= '0;
      q_sign    <= 1'b0;
      r_sign    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_TRAP_EN
      dz_pend   <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      dvd_sh    <= dvd_sh_d;
      dvs_mag   <= dvs_mag_d;
      rem       <= rem_d;
      q_sign    <= q_sign_d;
      r_sign    <= r_sign_d;
      busy      <= busy_d;
      done      <= done_d;
      dz        <= dz_d;
      quotient  <= quotient_d;
      remainder <= remainder_d;
`ifdef DIV_ZERO_TRAP_EN
      dz_pend   <= dz_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_signed_div_seq.sv
// Scoreboard bench for signed_div_seq: directed sign-magnitude divisions.
module tb_signed_div_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] dividend;
  logic [2:0] divisor;
  logic       busy;
  logic       done;
  logic [4:0] quotient;
  logic [2:0] remainder;
  logic       dz;

  typedef struct packed {
    logic [4:0] q;
    logic [2:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  signed_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy stuck high, expected idle within 40 cycles");
    end
  endtask

  // Issue one operation and push its expected result; optionally measure timing.
  task automatic do_op(input logic [4:0] a, input logic [2:0] b,
                       input logic [4:0] eq, input logic [2:0] er, input logic edz,
                       input bit chk_lat);
    int lat;
    int busy_cyc;
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back('{q: eq, r: er, dz: edz});
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_cyc = busy ? 1 : 0;
    lat      = 0;
    if (chk_lat) begin
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        lat++;
        if (busy) busy_cyc++;
        if (done) break;
      end
      check("done_latency", lat, 5);
      check("busy_cycles", busy_cyc, 5);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Monitor: pop and compare whenever the DUT presents a result.
    fork
      forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: q=%b r=%b dz=%b with no operation pending",
                     quotient, remainder, dz);
          end else begin
            e = sb.pop_front();
            check("quotient", int'(quotient), int'(e.q));
            check("remainder", int'(remainder), int'(e.r));
            check("dz", int'(dz), int'(e.dz));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dz", int'(dz), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(5'b00110, 3'b010, 5'b00011, 3'b000, 1'b0, 1'b1);  // 6 / 2
    do_op(5'b11001, 3'b010, 5'b10100, 3'b101, 1'b0, 1'b0);  // -9 / 2
    do_op(5'b00110, 3'b111, 5'b10010, 3'b000, 1'b0, 1'b0);  // 6 / -3
    do_op(5'b11111, 3'b011, 5'b10101, 3'b000, 1'b0, 1'b0);  // -15 / 3
    do_op(5'b11110, 3'b111, 5'b00100, 3'b110, 1'b0, 1'b0);  // -14 / -3
    do_op(5'b10000, 3'b011, 5'b00000, 3'b000, 1'b0, 1'b0);  // -0 / 3
    do_op(5'b01111, 3'b001, 5'b01111, 3'b000, 1'b0, 1'b0);  // 15 / 1
`ifdef DIV_ZERO_TRAP_EN
    do_op(5'b00101, 3'b000, 5'b01111, 3'b000, 1'b1, 1'b0);  // 5 / 0
    do_op(5'b00111, 3'b100, 5'b01111, 3'b000, 1'b1, 1'b0);  // 7 / -0
`else
    do_op(5'b00101, 3'b000, 5'b01111, 3'b001, 1'b0, 1'b0);  // 5 / 0
    do_op(5'b00111, 3'b100, 5'b01111, 3'b011, 1'b0, 1'b0);  // 7 / -0
`endif

    // start held through CALC and DONE with changing operands: only 13/2 counts.
    wait_idle();
    dividend = 5'b01101;
    divisor  = 3'b010;
    start    = 1'b1;
    sb.push_back('{q: 5'b00110, r: 3'b001, dz: 1'b0});
    @(posedge clk);
    #1;
    dividend = 5'b00001;
    divisor  = 3'b001;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;

    // Asynchronous reset in the middle of CALC clears everything at once.
    wait_idle();
    dividend = 5'b00110;
    divisor  = 3'b010;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_quotient", int'(quotient), 0);
    check("midrst_remainder", int'(remainder), 0);
    check("midrst_dz", int'(dz), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(5'b01001, 3'b001, 5'b01001, 3'b000, 1'b0, 1'b0);  // 9 / 1 after reset

    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    repeat (10) @(posedge clk);
    #2;
    check("pending_results", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
